// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-side issue bus between decode and the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
);
    logic                flush;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rs_addr;
    logic                issue_rs_used;
    logic [ADDR_W-1:0]   issue_rt_addr;
    logic                issue_rt_used;
    logic                issue_we;
    logic [ADDR_W-1:0]   issue_waddr;
    logic                issue_is_load;
    logic                stall;
    logic                issue_fire;
    logic [NUM_REGS-1:0] busy_mask;
    logic [31:0]         stall_count;

    modport master (
        output flush, issue_valid, issue_rs_addr, issue_rs_used, issue_rt_addr,
               issue_rt_used, issue_we, issue_waddr, issue_is_load,
        input  stall, issue_fire, busy_mask, stall_count
    );

    modport slave (
        input  flush, issue_valid, issue_rs_addr, issue_rs_used, issue_rt_addr,
               issue_rt_used, issue_we, issue_waddr, issue_is_load,
        output stall, issue_fire, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard producing decode stall and issue strobe
module hazard_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 5,
    parameter int FORWARDING = 1,
    parameter int ALU_LAT    = 1,
    parameter int LOAD_LAT   = 2,
    parameter int WB_LAT     = 3
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave sb
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] ALU_M1  = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] LOAD_M1 = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] WB_M1   = CNT_W'(WB_LAT - 1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [(1<<ADDR_W)-1:0]         busy_ext;
    logic [CNT_W-1:0]               lat_m1;
    logic                           hz_rs;
    logic                           hz_rt;
    logic                           set_w;

    // busy mask from counters; padded view makes out-of-range addresses read idle
    always_comb begin
        sb.busy_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) sb.busy_mask[i] = cnt[i] != '0;
        busy_ext = '0;
        busy_ext[NUM_REGS-1:0] = sb.busy_mask;
    end

    // hazard detection on pre-update state, issue strobe and writer latency
    always_comb begin
        hz_rs         = sb.issue_rs_used & busy_ext[sb.issue_rs_addr];
        hz_rt         = sb.issue_rt_used & busy_ext[sb.issue_rt_addr];
        sb.stall      = sb.issue_valid & (hz_rs | hz_rt) & ~sb.flush;
        sb.issue_fire = sb.issue_valid & ~sb.stall & ~sb.flush;
        set_w         = sb.issue_fire & sb.issue_we;
        lat_m1        = FORWARDING != 0 ? (sb.issue_is_load ? LOAD_M1 : ALU_M1) : WB_M1;
    end

    // counters: flush clears, youngest issued writer reloads, others count down; r0 stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else
            for (int i = 1; i < NUM_REGS; i++)
                cnt[i] <= sb.flush ? '0 :
                          (set_w && sb.issue_waddr == ADDR_W'(i)) ? lat_m1 :
                          cnt[i] != '0 ? cnt[i] - 1'b1 : '0;
    end

    // saturating count of stalled decode cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sb.stall_count <= '0;
        else if (sb.stall && sb.stall_count != '1) sb.stall_count <= sb.stall_count + 1'b1;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised per-register hazard tracker for the in-order MIPS pipeline.
- Generalises the fixed one-stage load-use stall in decode to configurable result latencies per instruction class, plus a no-forwarding mode.
- Sits beside decode: consumes the decoded source and destination fields, and produces the decode stall, an issue strobe and a busy mask.
- Holds one countdown counter per architectural register.

Parameters:
- NUM_REGS, 32: architectural register count; register 0 is hardwired zero.
- ADDR_W, 5: register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- FORWARDING, 1: 1 = bypass network present, use ALU_LAT/LOAD_LAT; 0 = no bypass, every writer uses WB_LAT.
- ALU_LAT, 1: minimum issue distance in cycles between a non-load writer and a dependent reader (forwarding mode).
- LOAD_LAT, 2: same distance for a load writer (forwarding mode).
- WB_LAT, 3: same distance for any writer when FORWARDING=0.
- Legal range for every latency: 1..15. Counter width CNT_W = 4 (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash in-flight writers (branch/jump redirect).
- issue_valid  in  1  decode holds a valid instruction.
- issue_rs_addr  in  ADDR_W  rs source address.
- issue_rs_used  in  1  instruction reads rs.
- issue_rt_addr  in  ADDR_W  rt source address.
- issue_rt_used  in  1  instruction reads rt.
- issue_we  in  1  instruction writes a register.
- issue_waddr  in  ADDR_W  destination register.
- issue_is_load  in  1  destination value comes from memory.
- stall  out  1  hold decode/fetch this cycle (combinational).
- issue_fire  out  1  instruction leaves decode this cycle (combinational).
- busy_mask  out  NUM_REGS  bit i set when cnt[i] != 0 (registered state).
- stall_count  out  32  saturating count of cycles with stall=1.

Behaviour:
- State: cnt[i] (CNT_W bits) for i = 1..NUM_REGS-1.
  - cnt[0] is constant 0; register 0 is never busy.
- Reset (async, rst=1): all cnt=0, stall_count=0. Consequently busy_mask=0 and stall=0 with issue_valid=0.
- Combinational outputs:
  - hz_rs = issue_rs_used & (issue_rs_addr != 0) & (cnt[issue_rs_addr] != 0); hz_rt is the same for rt.
  - stall = issue_valid & (hz_rs | hz_rt) & ~flush.
  - issue_fire = issue_valid & ~stall & ~flush.
- Latency select: L = FORWARDING ? (issue_is_load ? LOAD_LAT : ALU_LAT) : WB_LAT.
- Per-cycle update, in priority order:
  1. flush=1: every cnt <- 0. A same-cycle issue is discarded (decode is squashed). stall forced 0.
  2. Otherwise, for register w = issue_waddr with issue_fire & issue_we & (w != 0): cnt[w] <- L-1. This overwrites any older pending value; the youngest writer governs.
  3. Every other register with cnt != 0: cnt <- cnt-1.
- Timing: a writer issued in cycle t with latency L makes a dependent reader stall in cycles t+1 .. t+L-1 and issue in cycle t+L.
  - Example: LOAD_LAT=2 gives exactly one bubble; ALU_LAT=1 gives none.
- Reader equals writer (e.g. addiu r5,r5,1): the hazard check uses pre-update cnt, so the instruction's own write never stalls itself.
- Issue with stall=1: no counter is set; counters still decrement.
- Issue of a register-0 destination: no state change.
- stall_count: increments when stall=1; holds at 32'hFFFF_FFFF; unaffected by flush.
- rst asserted mid-operation clears all state immediately. The first edge after rst deasserts behaves as after power-up.
- Out-of-range addresses (>= NUM_REGS) read as not busy and are ignored as destinations.

Test Plan:
- Reset: assert rst with cnt[7]=1 pending -> busy_mask=0, stall_count=0 immediately, before any clock edge.
- Load-use (FORWARDING=1, LOAD_LAT=2): issue load to r8 at t; reader of r8 (rs) valid at t+1 -> stall=1 at t+1, issue_fire=1 at t+2, stall_count=1.
- ALU back-to-back: addu r3 at t, reader of r3 via rt at t+1 -> stall=0, issue_fire=1; busy_mask[3] never set.
- No-forwarding (FORWARDING=0, WB_LAT=3): ALU write to r4 at t, reader at t+1 -> stall at t+1 and t+2, fires at t+3; busy_mask[4] high during t+1..t+2.
- Flush precedence: load to r9 at t; at t+1 a reader of r9 with flush=1 -> stall=0, issue_fire=0, busy_mask=0 at t+2; a reader of r9 at t+2 fires.
- Overwrite/zero: load to r6 at t, then addu r6 at t+1 with no sources -> cnt[6]=0 at t+2. Separately, a load to r0 never sets busy_mask, and a reader of r0 never stalls.
